// File: rtl/perf_counter_bank.sv
// perf_counter_bank
//   Cycle counter plus NUM_CH event counters. Counting runs only in RUN.
//   All counts freeze once halt is seen. A registered read port exposes any
//   counter, so statistics can be sampled without hierarchical probes.
//
//   Build option: define PERF_SATURATE_EN to make counters saturate at
//   all-ones. Left undefined, they wrap to zero. In both builds, the first
//   increment past the maximum sets the counter's sticky ovf bit.
//
//   Ports
//     clk       system clock, rising edge
//     rst       synchronous active-high reset, overrides everything
//     enable    count enable (IDLE <-> RUN)
//     clear     synchronous clear of counters, flags, read data and state
//     event_in  per-channel event strobes, counted only in RUN cycles
//     halt      processor halt, moves RUN -> HALTED
//     rd_sel    0 = cycle counter, k = channel k-1, > NUM_CH reads 0
//     rd_data   registered read data (pre-update value, 1-cycle latency)
//     ovf       sticky overflow flags, bit 0 = cycle counter, bit k = channel k-1
//     state     0 = IDLE, 1 = RUN, 2 = HALTED
//     done      one-cycle pulse after the RUN -> HALTED edge
//
//   state  | meaning
//   IDLE   | not counting; counts retained (after reset, clear or pause)
//   RUN    | every cycle is counted, including the one where halt is seen
//   HALTED | counts frozen until clear or rst
module perf_counter_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] event_in,
  input  logic              halt,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH:0]   ovf,
  output logic [1:0]        state,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } stateT;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stateT            stateQ;
  stateT            stateNext;
  logic             counting;
  logic [NUM_CH:0]  incVec;
  logic [CNT_W-1:0] cntQ [NUM_CH+1];
  logic [CNT_W-1:0] rdMux;

  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      IDLE:    if (enable) stateNext = RUN;
      // halt wins over a simultaneous enable drop
      RUN:     if (halt) stateNext = HALTED;
               else if (!enable) stateNext = IDLE;
      HALTED:  stateNext = HALTED;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      stateQ <= IDLE;
      done   <= 1'b0;
    end else begin
      stateQ <= stateNext;
      done   <= (stateQ == RUN) && (stateNext == HALTED);
    end
  end

  assign state = stateQ;

  // The current state decides whether this edge counts, so the IDLE->RUN
  // edge is not counted but the halt edge is.
  assign counting = (stateQ == RUN);
  assign incVec   = {event_in & {NUM_CH{counting}}, counting};

  // Compare-based mux so an out-of-range rd_sel never indexes past the array.
  always_comb begin
    rdMux = '0;
    for (int k = 0; k <= NUM_CH; k++) begin
      if (rd_sel == SEL_W'(k)) rdMux = cntQ[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int k = 0; k <= NUM_CH; k++) cntQ[k] <= '0;
      ovf     <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= rdMux;
      for (int k = 0; k <= NUM_CH; k++) begin
        if (incVec[k]) begin
          if (cntQ[k] == CNT_MAX) begin
            ovf[k] <= 1'b1;
`ifdef PERF_SATURATE_EN
            cntQ[k] <= CNT_MAX;
`else
            cntQ[k] <= '0;
`endif
          end else begin
            cntQ[k] <= cntQ[k] + 1'b1;
          end
        end
      end
    end
  end

endmodule
